// File: rtl/md_sequencer_if.sv
// Command/result bundle between the EX-stage issue logic and the mult/div sequencer.
// cancel exists only in builds with MD_CANCEL_EN defined.
interface md_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MD_CANCEL_EN
    logic        cancel;
`endif

    modport master (
`ifdef MD_CANCEL_EN
        output cancel,
`endif
        output start, op, srcA, srcB,
        input  busy, hi, lo
    );

    modport slave (
`ifdef MD_CANCEL_EN
        input  cancel,
`endif
        input  start, op, srcA, srcB,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_sequencer.sv
// Mult/div sequencer owning HI/LO; result computed at issue, committed after a fixed latency.
// Latency: busy high MULT_CYCLES/DIV_CYCLES cycles from the cycle after start; MTHI/MTLO take one edge.
// Backpressure: none; starts arriving while busy are ignored (hazard unit stalls ID). Optional MD_CANCEL_EN adds cancel.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave md
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag;
    logic [31:0] sdiv_q, sdiv_r, udiv_q, udiv_r, udiv_den;
    logic        cmd_vld, div_zero;

    // Signed division runs on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        prod_s   = $signed({{32{md.srcA[31]}}, md.srcA}) * $signed({{32{md.srcB[31]}}, md.srcB});
        prod_u   = {32'd0, md.srcA} * {32'd0, md.srcB};
        div_zero = (md.srcB == 32'd0);
        a_mag    = md.srcA[31] ? -md.srcA : md.srcA;
        b_mag    = md.srcB[31] ? -md.srcB : md.srcB;
        b_den    = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_den;
        r_mag    = a_mag % b_den;
        sdiv_q   = (md.srcA[31] ^ md.srcB[31]) ? -q_mag : q_mag;
        sdiv_r   = md.srcA[31] ? -r_mag : r_mag;
        udiv_den = div_zero ? 32'd1 : md.srcB;
        udiv_q   = md.srcA / udiv_den;
        udiv_r   = md.srcA % udiv_den;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
`ifdef MD_CANCEL_EN
        cmd_vld  = md.start && !md.cancel;
`else
        cmd_vld  = md.start;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    case (md.op)
                        OP_MULT, OP_MULTU: begin
                            {res_hi_d, res_lo_d} = (md.op == OP_MULT) ? prod_s : prod_u;
                            count_d = MULT_CNT;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero commits the current HI/LO back unchanged.
                            if (div_zero) begin
                                res_hi_d = hi_q;
                                res_lo_d = lo_q;
                            end else if (md.op == OP_DIV) begin
                                res_hi_d = sdiv_r;
                                res_lo_d = sdiv_q;
                            end else begin
                                res_hi_d = udiv_r;
                                res_lo_d = udiv_q;
                            end
                            count_d = DIV_CNT;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = md.srcA;
                        OP_MTLO: lo_d = md.srcA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
`ifdef MD_CANCEL_EN
                if (md.cancel) begin
                    count_d = 4'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else
`endif
                if (count_q == 4'd1) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    count_d = 4'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed cases plus random commands against a longint reference model.
module tb_md_sequencer;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    md_sequencer_if mdif ();

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    // Apply one accepted command to the architectural model and return its busy length.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int cyc);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        cyc = 0;
        case (op)
            3'd1: begin p = sa * sb; ref_hi = p[63:32]; ref_lo = p[31:0]; cyc = MC; end
            3'd2: begin p = ua * ub; ref_hi = p[63:32]; ref_lo = p[31:0]; cyc = MC; end
            3'd3: begin
                cyc = DC;
                if (b != 0) begin q = sa / sb; r = sa % sb; ref_lo = q[31:0]; ref_hi = r[31:0]; end
            end
            3'd4: begin
                cyc = DC;
                if (b != 0) begin p = ua / ub; ref_lo = p[31:0]; p = ua % ub; ref_hi = p[31:0]; end
            end
            3'd5: ref_hi = a;
            3'd6: ref_lo = a;
            default: ;
        endcase
    endtask

    // Issue one command for a single cycle, count busy cycles, then compare HI/LO.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        int cyc, n;
        model_apply(op, a, b, cyc);
        mdif.start = 1'b1; mdif.op = op; mdif.srcA = a; mdif.srcB = b;
        @(posedge clk); #1;
        mdif.start = 1'b0; mdif.op = 3'd0;
        n = 0;
        while (mdif.busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        total++;
        if (n !== cyc) begin bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, n, cyc); end
        total++;
        if (mdif.hi !== ref_hi) begin bad++; $display("FAIL %s hi got=%h want=%h", name, mdif.hi, ref_hi); end
        total++;
        if (mdif.lo !== ref_lo) begin bad++; $display("FAIL %s lo got=%h want=%h", name, mdif.lo, ref_lo); end
    endtask

    task automatic test_reset();
        mdif.start = 1'b1; mdif.op = 3'd5; mdif.srcA = 32'hDEAD_BEEF; mdif.srcB = 32'd1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; mdif.start = 1'b0; mdif.op = 3'd0;
        ref_hi = 32'd0; ref_lo = 32'd0;
        total++;
        if (mdif.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", mdif.busy); end
        total++;
        if (mdif.hi !== 32'd0) begin bad++; $display("FAIL reset hi got=%h want=0", mdif.hi); end
        total++;
        if (mdif.lo !== 32'd0) begin bad++; $display("FAIL reset lo got=%h want=0", mdif.lo); end
    endtask

    task automatic test_mult();
        do_cmd(3'd1, 32'd3, 32'hFFFF_FFFE, "mult");
        total++;
        if ({mdif.hi, mdif.lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            bad++; $display("FAIL mult_const got=%h want=fffffffffffffffa", {mdif.hi, mdif.lo});
        end
        do_cmd(3'd2, 32'hFFFF_FFFF, 32'd2, "multu");
        total++;
        if ({mdif.hi, mdif.lo} !== 64'h0000_0001_FFFF_FFFE) begin
            bad++; $display("FAIL multu_const got=%h want=00000001fffffffe", {mdif.hi, mdif.lo});
        end
    endtask

    task automatic test_div();
        do_cmd(3'd3, 32'd7, 32'hFFFF_FFFE, "div");
        total++;
        if ({mdif.hi, mdif.lo} !== 64'h0000_0001_FFFF_FFFD) begin
            bad++; $display("FAIL div_const got=%h want=00000001fffffffd", {mdif.hi, mdif.lo});
        end
        do_cmd(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        total++;
        if ({mdif.hi, mdif.lo} !== 64'h0000_0000_8000_0000) begin
            bad++; $display("FAIL div_ovf_const got=%h want=0000000080000000", {mdif.hi, mdif.lo});
        end
        do_cmd(3'd3, 32'hFFFF_FFF9, 32'd2, "div_negdividend");
    endtask

    task automatic test_div_zero();
        logic [31:0] lo_before;
        do_cmd(3'd5, 32'h1234_5678, 32'd0, "mthi");
        lo_before = ref_lo;
        do_cmd(3'd4, 32'd5, 32'd0, "divu_zero");
        total++;
        if (mdif.hi !== 32'h1234_5678 || mdif.lo !== lo_before) begin
            bad++; $display("FAIL divu_zero_keep got=%h_%h want=12345678_%h", mdif.hi, mdif.lo, lo_before);
        end
        do_cmd(3'd3, 32'hFFFF_0000, 32'd0, "div_zero");
    endtask

    task automatic test_ignore_during_busy();
        int cyc, n;
        model_apply(3'd3, 32'd100, 32'd7, cyc);
        mdif.start = 1'b1; mdif.op = 3'd3; mdif.srcA = 32'd100; mdif.srcB = 32'd7;
        @(posedge clk); #1;
        mdif.op = 3'd6; mdif.srcA = 32'h0000_AAAA;
        n = 0;
        while (mdif.busy && n < 40) begin
            n++;
            if (n == 4) begin mdif.start = 1'b0; mdif.op = 3'd0; end
            @(posedge clk); #1;
        end
        mdif.start = 1'b0; mdif.op = 3'd0;
        total++;
        if (n !== cyc) begin bad++; $display("FAIL ignore busy_cycles got=%0d want=%0d", n, cyc); end
        total++;
        if (mdif.lo !== ref_lo) begin bad++; $display("FAIL ignore lo got=%h want=%h", mdif.lo, ref_lo); end
        total++;
        if (mdif.hi !== ref_hi) begin bad++; $display("FAIL ignore hi got=%h want=%h", mdif.hi, ref_hi); end
    endtask

    task automatic test_reset_during_busy();
        mdif.start = 1'b1; mdif.op = 3'd1; mdif.srcA = 32'd9; mdif.srcB = 32'd11;
        @(posedge clk); #1;
        mdif.start = 1'b0; mdif.op = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0;
        total++;
        if (mdif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy busy got=%b want=0", mdif.busy); end
        total++;
        if (mdif.hi !== 32'd0 || mdif.lo !== 32'd0) begin
            bad++; $display("FAIL rst_busy hilo got=%h_%h want=0_0", mdif.hi, mdif.lo);
        end
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (mdif.lo !== 32'd0 || mdif.busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy discard lo=%h busy=%b want=0/0", mdif.lo, mdif.busy);
        end
    endtask

    task automatic test_back_to_back();
        do_cmd(3'd2, 32'h0001_0000, 32'h0001_0000, "b2b_multu");
        do_cmd(3'd3, 32'hFFFF_FF9C, 32'd7, "b2b_div");
        do_cmd(3'd6, 32'h0BAD_F00D, 32'd0, "b2b_mtlo");
        do_cmd(3'd1, 32'h8000_0000, 32'h8000_0000, "b2b_mult");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_cmd(op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end
    endtask

`ifdef MD_CANCEL_EN
    task automatic test_cancel();
        logic [31:0] h0, l0;
        int n;
        do_cmd(3'd5, 32'h5555_0001, 32'd0, "cx_mthi");
        do_cmd(3'd6, 32'h5555_0002, 32'd0, "cx_mtlo");
        h0 = ref_hi; l0 = ref_lo;
        mdif.start = 1'b1; mdif.op = 3'd3; mdif.srcA = 32'd1000; mdif.srcB = 32'd3;
        @(posedge clk); #1;
        mdif.start = 1'b0; mdif.op = 3'd0;
        repeat (3) begin @(posedge clk); #1; end
        mdif.cancel = 1'b1;
        @(posedge clk); #1;
        mdif.cancel = 1'b0;
        total++;
        if (mdif.busy !== 1'b0) begin bad++; $display("FAIL cancel busy got=%b want=0", mdif.busy); end
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (mdif.hi !== h0 || mdif.lo !== l0) begin
            bad++; $display("FAIL cancel hilo got=%h_%h want=%h_%h", mdif.hi, mdif.lo, h0, l0);
        end
        mdif.start = 1'b1; mdif.op = 3'd5; mdif.srcA = 32'h7777_7777; mdif.cancel = 1'b1;
        @(posedge clk); #1;
        mdif.start = 1'b0; mdif.op = 3'd0; mdif.cancel = 1'b0;
        total++;
        if (mdif.hi !== h0 || mdif.busy !== 1'b0) begin
            bad++; $display("FAIL cancel_start hi=%h busy=%b want=%h/0", mdif.hi, mdif.busy, h0);
        end
        mdif.start = 1'b1; mdif.op = 3'd1; mdif.srcA = 32'd6; mdif.srcB = 32'd7;
        @(posedge clk); #1;
        mdif.start = 1'b0; mdif.op = 3'd0;
        n = 1;
        while (n < MC) begin n++; @(posedge clk); #1; end
        mdif.cancel = 1'b1;
        @(posedge clk); #1;
        mdif.cancel = 1'b0;
        total++;
        if (mdif.busy !== 1'b0 || mdif.lo !== l0) begin
            bad++; $display("FAIL cancel_commit lo=%h busy=%b want=%h/0", mdif.lo, mdif.busy, l0);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        mdif.start = 1'b0; mdif.op = 3'd0; mdif.srcA = 32'd0; mdif.srcB = 32'd0;
`ifdef MD_CANCEL_EN
        mdif.cancel = 1'b0;
`endif
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignore_during_busy();
        test_back_to_back();
        test_reset_during_busy();
        test_random();
`ifdef MD_CANCEL_EN
        test_cancel();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
